// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: controller state encoding.
// Pure types; no timing or flow-control behaviour of its own.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit combinational ripple adder built from full-adder cells; zero latency.
// Also exposes the carry into the slice MSB for signed-overflow detection; no flow control.
module one_bit_fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    one_bit_fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout  = carry[DIGIT];
  assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH/DIGIT cycles per sum, LSB slice first, done pulses when S is published.
// start is only honoured in IDLE/DONE; requests during RUN are dropped, so callers must wait for done.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N) + 1;

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_adder: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
  end

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nxt;
  logic             carry_q;
  logic             accept, last;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout, slice_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  // New slice enters at the top; after N shifts the full sum is aligned.
  assign sum_nxt = WIDTH'({slice_sum, sum_q} >> DIGIT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    last      = (cnt_q == CNT_W'(N - 1));
    case (state_q)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      S        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      carry_q <= slice_cout;
      cnt_q   <= cnt_q + CNT_W'(1);
      sum_q   <= sum_nxt;
      if (last) begin
        S        <= sum_nxt;
        cout     <= slice_cout;
        overflow <= slice_cmsb ^ slice_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Exercises serial_adder at DIGIT=4, 1 and 16 against an arithmetic reference model.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic        cin_v   [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic [15:0] s_o     [3];
  logic        cout_o  [3];
  logic        ov_o    [3];

  int n_chk  = 0;
  int n_fail = 0;
  int nd [3] = '{4, 16, 1};

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
    .busy(busy_o[0]), .done(done_o[0]), .S(s_o[0]), .cout(cout_o[0]), .overflow(ov_o[0]));

  serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]),
    .busy(busy_o[1]), .done(done_o[1]), .S(s_o[1]), .cout(cout_o[1]), .overflow(ov_o[1]));

  serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]),
    .busy(busy_o[2]), .done(done_o[2]), .S(s_o[2]), .cout(cout_o[2]), .overflow(ov_o[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, cout, S} from plain integer arithmetic.
  function automatic logic [17:0] ref_add(input logic [15:0] av, input logic [15:0] bv,
                                          input logic ci);
    logic [16:0] t;
    logic        ov;
    t  = {1'b0, av} + {1'b0, bv} + {16'd0, ci};
    ov = (av[15] == bv[15]) && (t[15] != av[15]);
    return {ov, t[16], t[15:0]};
  endfunction

  task automatic drive(input int k, input logic st, input logic [15:0] av,
                       input logic [15:0] bv, input logic ci);
    start_v[k] = st;
    a_v[k]     = av;
    b_v[k]     = bv;
    cin_v[k]   = ci;
  endtask

  // Entered 1ns after an edge; returns cycles until done and busy-high samples seen.
  task automatic wait_done(input int k, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (done_o[k] !== 1'b1 && lat < 40) begin
      if (busy_o[k] === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input int k, input string tag, input logic [17:0] exp);
    chk({tag, "_S"},    32'(s_o[k]),    32'(exp[15:0]));
    chk({tag, "_cout"}, 32'(cout_o[k]), 32'(exp[16]));
    chk({tag, "_ovf"},  32'(ov_o[k]),   32'(exp[17]));
  endtask

  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input string tag);
    int lat, bc;
    logic [17:0] exp;
    exp = ref_add(av, bv, ci);
    drive(k, 1'b1, av, bv, ci);
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    wait_done(k, lat, bc);
    chk({tag, "_lat"},  32'(lat), 32'(nd[k]));
    chk({tag, "_busy"}, 32'(bc),  32'(nd[k]));
    check_result(k, tag, exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(done_o[k]), 32'd0);
    check_result(k, {tag, "_hold"}, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, seen;
    logic [15:0] ra, rb;
    logic        rc;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", 32'(busy_o[k]), 32'd0);
      chk("rst_done", 32'(done_o[k]), 32'd0);
      check_result(k, "rst", 18'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, 16'h1234, 16'h4321, 1'b0, "basic_d4");
    run_op(0, 16'hFFFF, 16'h0000, 1'b1, "cin_wrap");
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, "pos_ovf");
    run_op(0, 16'h8000, 16'h8000, 1'b0, "neg_ovf");

    // start pulsed with new operands during RUN must be ignored.
    drive(0, 1'b1, 16'h1234, 16'h4321, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 16'hAAAA, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, lat, bc);
    chk("busy_start_lat", 32'(lat), 32'd2);
    check_result(0, "busy_start", ref_add(16'h1234, 16'h4321, 1'b0));
    @(posedge clk); #1;
    chk("busy_start_pulse", 32'(done_o[0]), 32'd0);
    chk("busy_start_idle",  32'(busy_o[0]), 32'd0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_o[0] === 1'b1) seen++;
    end
    chk("busy_start_nodone", 32'(seen), 32'd0);

    // start held through DONE chains a second addition.
    drive(0, 1'b1, 16'h1234, 16'h4321, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 16'h0001, 16'h0002, 1'b0);
    wait_done(0, lat, bc);
    chk("b2b_lat1", 32'(lat), 32'd4);
    check_result(0, "b2b_first", ref_add(16'h1234, 16'h4321, 1'b0));
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, lat, bc);
    chk("b2b_gap", 32'(lat + 1), 32'd5);
    check_result(0, "b2b_second", ref_add(16'h0001, 16'h0002, 1'b0));
    @(posedge clk); #1;

    // Reset at the second RUN edge aborts without publishing.
    drive(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy_o[0]), 32'd0);
    chk("abort_done", 32'(done_o[0]), 32'd0);
    check_result(0, "abort", 18'd0);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_o[0] === 1'b1) seen++;
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    run_op(0, 16'h0F0F, 16'h00F1, 1'b1, "after_abort");

    run_op(1, 16'h1234, 16'h4321, 1'b0, "basic_d1");
    run_op(2, 16'h1234, 16'h4321, 1'b0, "basic_d16");
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, "pos_ovf_d1");
    run_op(2, 16'h8000, 16'h8000, 1'b0, "neg_ovf_d16");

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        run_op(k, ra, rb, rc, "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, meaning bits added per clock cycle; WIDTH%DIGIT==0 and 1<=DIGIT<=WIDTH are required.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin an addition.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in.
REQ-009 SHALL have port busy  output  1  addition in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a result is published.
REQ-011 SHALL have port S  output  WIDTH  registered sum.
REQ-012 SHALL have port cout  output  1  registered carry-out of bit WIDTH-1.
REQ-013 SHALL have port overflow  output  1  registered two's-complement overflow flag.

Function
REQ-014 SHALL use N = WIDTH/DIGIT digit cycles per addition.
REQ-015 SHALL implement states IDLE, RUN and DONE; IDLE->RUN on start; RUN->DONE after N digit cycles; DONE->RUN on start, else DONE->IDLE.
REQ-016 SHALL accept start only in IDLE or DONE, capturing a, b and cin at that edge (E0).
REQ-017 SHALL ignore start, a, b and cin while in RUN.
REQ-018 SHALL add one DIGIT-bit slice per edge E1..EN, least significant slice first, with the carry chained through a carry register.
REQ-019 SHALL assert busy exactly while in RUN, i.e. from E0 to EN.
REQ-020 SHALL update S, cout and overflow at EN and assert done for the single cycle EN..EN+1 (latency N cycles).
REQ-021 SHALL hold S, cout and overflow unchanged from the last publish until the next publish.
REQ-022 SHALL compute overflow as (carry into bit WIDTH-1) XOR cout.
REQ-023 SHALL produce results modulo 2^WIDTH, with the carry out of bit WIDTH-1 reported only on cout.
REQ-024 SHALL support back-to-back operation: a start sampled in DONE yields the next done exactly N+1 cycles after the previous done.
REQ-025 SHALL, when DIGIT==WIDTH (N=1), complete in one RUN cycle with identical handshake.

Reset
REQ-026 SHALL, on any clk edge with rst=1, enter IDLE and drive busy=0, done=0, S=0, cout=0 and overflow=0, and clear the digit counter, carry register and operand registers.
REQ-027 SHALL give rst priority over start and over any in-flight addition; an aborted addition SHALL never publish or assert done.

Structure
REQ-028 SHALL take the state encoding (IDLE/RUN/DONE) from the shared package serial_adder_pkg.
REQ-029 SHALL instantiate one sub-module digit_adder (DIGIT-bit ripple adder built from one_bit_fulladder cells) that outputs the slice sum, the slice carry-out and the carry into the slice MSB.
REQ-030 SHALL size the digit counter at $clog2(N)+1 bits, with no other arithmetic wider than DIGIT+1.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-031 SHALL cover: a=0x1234, b=0x4321, cin=0 -> S=0x5555, cout=0, overflow=0, done exactly 4 cycles after start edge, busy high for 4 cycles.
REQ-032 SHALL cover: a=0xFFFF, b=0x0000, cin=1 -> S=0x0000, cout=1, overflow=0.
REQ-033 SHALL cover: a=0x7FFF, b=0x0001, cin=0 -> S=0x8000, cout=0, overflow=1; then a=0x8000, b=0x8000 -> S=0x0000, cout=1, overflow=1.
REQ-034 SHALL cover: start while busy with a=0xAAAA, b=0x1111 -> ignored, first result published unchanged, single done.
REQ-035 SHALL cover: start held high through DONE with a=0x0001, b=0x0002 -> second done 5 cycles after first, S=0x0003.
REQ-036 SHALL cover: rst asserted at 2nd RUN cycle -> no done, all outputs 0 next cycle; next addition correct; repeat REQ-031 with DIGIT=1 (done after 16 cycles) and DIGIT=16 (done after 1 cycle).
